// File: rtl/four_bank_mem_resp_if.sv
// Request/response bundle between the cache controller (master) and the
// four-bank memory responder (slave).
interface four_bank_mem_resp_if;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_BANKS = 4;

  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem_resp.sv
// Four-bank interleaved word memory standing in for main memory below the
// cache FSM. Each accepted access occupies its bank for four cycles and read
// data returns two cycles after acceptance.
// Optional macro MEM_REQ_CHECK_EN: flags rd&wr and odd addresses as erroneous
// requests (err pulse, no access). Undefined: err tied low, addr[0] ignored,
// rd&wr handled as a write.
module four_bank_mem_resp #(
  parameter int unsigned MEM_WORDS_LOG2 = 10
) (
  input logic                 clk,
  input logic                 rst,
  four_bank_mem_resp_if.slave bus
);
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BANK_W    = 2;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned DEPTH     = 1 << MEM_WORDS_LOG2;
  localparam logic [CNT_W-1:0] OCC_LOAD = CNT_W'(4);

  logic [DATA_W-1:0]         mem [DEPTH];
  logic [CNT_W-1:0]          cnt [NUM_BANKS];
  logic [NUM_BANKS-1:0]      busy_vec;
  logic [BANK_W-1:0]         bank;
  logic [MEM_WORDS_LOG2-1:0] idx;
  logic                      req;
  logic                      bank_busy;
  logic                      bad;
  logic                      accept;
  logic                      do_wr;
  logic                      do_rd;
  logic                      s1_valid;
  logic [DATA_W-1:0]         s1_data;
  logic [DATA_W-1:0]         s2_data;
  logic                      err_q;
  logic                      unused_addr;

  assign bank = bus.addr[2:1];
  assign idx  = bus.addr[MEM_WORDS_LOG2:1];
  assign req  = bus.rd | bus.wr;

  // Per-bank occupancy flags derived from the down-counters.
  always_comb begin
    busy_vec = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      busy_vec[b] = (cnt[b] != '0);
    end
  end

  assign bank_busy = busy_vec[bank];

`ifdef MEM_REQ_CHECK_EN
  assign bad = req & ~bank_busy & ((bus.rd & bus.wr) | bus.addr[0]);
`else
  assign bad = 1'b0;
`endif

  // A stalled or erroneous request has no side effects; reset blocks acceptance.
  assign accept = req & ~bank_busy & ~bad & rst;
  assign do_wr  = accept & bus.wr;
  assign do_rd  = accept & bus.rd & ~bus.wr;

  // Bank occupancy counters: load on acceptance, count down to idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (accept && (bank == BANK_W'(b))) begin
          cnt[b] <= OCC_LOAD;
        end else if (cnt[b] != '0) begin
          cnt[b] <= cnt[b] - CNT_W'(1);
        end
      end
    end
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[idx] <= bus.data_in;
    end
  end

  // Two-stage read return pipeline plus error pulse; stage 2 holds zero when empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= do_rd;
      s1_data  <= mem[idx];
      s2_data  <= s1_valid ? s1_data : '0;
      err_q    <= bad;
    end
  end

  assign bus.data_out = s2_data;
  assign bus.busy     = busy_vec;
  assign bus.err      = err_q;
  assign bus.stall    = req & bank_busy;

  // Address bits above the word index alias; addr[0] only matters with checking on.
  assign unused_addr = ^{bus.addr[15:MEM_WORDS_LOG2+1], bus.addr[0]};
endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Directed bench for four_bank_mem_resp: stimulus pushes expected read data
// and error pulses into queues; a negedge monitor compares every cycle.
module tb_four_bank_mem_resp;
  typedef struct {
    int          cyc;
    logic        care;
    logic [15:0] data;
  } rexp_t;

  logic  clk;
  logic  rst;
  int    cyc;
  int    checks;
  int    errors;
  logic  mon_en;
  rexp_t rq[$];
  int    eq[$];

  four_bank_mem_resp_if bus();

  four_bank_mem_resp #(.MEM_WORDS_LOG2(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: data_out must match the queued read for this cycle, else be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] exp_d;
      logic        care;
      logic        exp_e;
      exp_d = 16'h0000;
      care  = 1'b1;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rexp_t e;
        e     = rq.pop_front();
        exp_d = e.data;
        care  = e.care;
      end
      if (care) chk("data_out", bus.data_out, exp_d);
      exp_e = 1'b0;
      if (eq.size() > 0 && eq[0] == cyc) begin
        void'(eq.pop_front());
        exp_e = 1'b1;
      end
      chk("err", {15'b0, bus.err}, {15'b0, exp_e});
    end
  end

  // Present a request, hold it through stalls, queue its expected response.
  task automatic req(input logic r, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input int exp_stalls, input logic care,
                     input logic [15:0] exp_rd, input logic exp_err);
    int    n;
    rexp_t e;
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.stall || n > 20) break;
      n++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 16'(n), 16'(exp_stalls));
    if (exp_err) begin
      eq.push_back(cyc + 1);
    end else if (r && !w) begin
      e.cyc  = cyc + 2;
      e.care = care;
      e.data = exp_rd;
      rq.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    mon_en      = 1'b0;
    rst         = 1'b0;
    bus.rd      = 1'b1;
    bus.wr      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;

    // Reset held two cycles with a read pending.
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", {12'b0, bus.busy}, 16'h0000);
    chk("reset_stall", {15'b0, bus.stall}, 16'h0000);
    @(posedge clk); #1;
    rst    = 1'b1;
    bus.rd = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {12'b0, bus.busy}, 16'h0000);
    chk("post_reset_stall_idle", {15'b0, bus.stall}, 16'h0000);
    @(posedge clk); #1;
    req(1'b1, 1'b0, 16'h0000, 16'h0, 0, 1'b0, 16'h0, 1'b0);
    idle(5);

    // Write bank 1, then a read to the same bank stalls until cycle 5.
    req(1'b0, 1'b1, 16'h0002, 16'hBEEF, 0, 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    chk("busy_after_wr", {12'b0, bus.busy}, 16'h0002);
    @(posedge clk); #1;
    req(1'b1, 1'b0, 16'h0002, 16'h0, 3, 1'b1, 16'hBEEF, 1'b0);
    idle(6);

    // Preload and back-to-back reads across all banks.
    req(1'b0, 1'b1, 16'h0000, 16'h0001, 0, 1'b1, 16'h0, 1'b0);
    req(1'b0, 1'b1, 16'h0002, 16'h0002, 0, 1'b1, 16'h0, 1'b0);
    req(1'b0, 1'b1, 16'h0004, 16'h0003, 0, 1'b1, 16'h0, 1'b0);
    req(1'b0, 1'b1, 16'h0006, 16'h0004, 0, 1'b1, 16'h0, 1'b0);
    idle(5);
    req(1'b1, 1'b0, 16'h0000, 16'h0, 0, 1'b1, 16'h0001, 1'b0);
    req(1'b1, 1'b0, 16'h0002, 16'h0, 0, 1'b1, 16'h0002, 1'b0);
    req(1'b1, 1'b0, 16'h0004, 16'h0, 0, 1'b1, 16'h0003, 1'b0);
    req(1'b1, 1'b0, 16'h0006, 16'h0, 0, 1'b1, 16'h0004, 1'b0);
    @(negedge clk);
    chk("busy_all", {12'b0, bus.busy}, 16'h000F);
    @(posedge clk); #1;
    idle(6);

    req(1'b0, 1'b1, 16'h0010, 16'h5555, 0, 1'b1, 16'h0, 1'b0);
    idle(5);
`ifdef MEM_REQ_CHECK_EN
    // Odd address: error pulse, bank stays free, no data.
    req(1'b1, 1'b0, 16'h0003, 16'h0, 0, 1'b1, 16'h0, 1'b1);
    @(negedge clk);
    chk("busy_after_err", {12'b0, bus.busy}, 16'h0000);
    @(posedge clk); #1;
    // rd&wr: error pulse, word untouched.
    req(1'b1, 1'b1, 16'h0010, 16'hAAAA, 0, 1'b1, 16'h0, 1'b1);
    // Held erroneous request pulses each cycle.
    bus.rd   = 1'b1;
    bus.addr = 16'h0005;
    @(negedge clk); eq.push_back(cyc + 1);
    @(posedge clk); #1;
    @(negedge clk); eq.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.rd = 1'b0;
    idle(1);
    req(1'b1, 1'b0, 16'h0010, 16'h0, 0, 1'b1, 16'h5555, 1'b0);
`else
    // rd&wr acts as a write with no read return; addr[0] is ignored.
    req(1'b1, 1'b1, 16'h0010, 16'h7777, 0, 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    chk("busy_after_rdwr", {12'b0, bus.busy}, 16'h0001);
    @(posedge clk); #1;
    idle(4);
    req(1'b1, 1'b0, 16'h0011, 16'h0, 0, 1'b1, 16'h7777, 1'b0);
`endif
    idle(6);

    // Reset while a read is in flight; a write during reset is dropped.
    bus.rd   = 1'b1;
    bus.addr = 16'h0004;
    @(negedge clk);
    chk("midrd_stall", {15'b0, bus.stall}, 16'h0000);
    @(posedge clk); #1;
    bus.rd      = 1'b0;
    bus.wr      = 1'b1;
    bus.addr    = 16'h0006;
    bus.data_in = 16'hDEAD;
    rst         = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b1;
    bus.wr = 1'b0;
    @(negedge clk);
    chk("midrd_busy", {12'b0, bus.busy}, 16'h0000);
    @(posedge clk); #1;
    req(1'b1, 1'b0, 16'h0004, 16'h0, 0, 1'b1, 16'h0003, 1'b0);
    req(1'b1, 1'b0, 16'h0006, 16'h0, 0, 1'b1, 16'h0004, 1'b0);
    idle(6);

    // Aliasing above the word index.
    req(1'b0, 1'b1, 16'h0800, 16'h1234, 0, 1'b1, 16'h0, 1'b0);
    idle(5);
    req(1'b1, 1'b0, 16'h0000, 16'h0, 0, 1'b1, 16'h1234, 1'b0);
    idle(5);

    chk("rd_queue_drained", 16'(rq.size()), 16'h0000);
    chk("err_queue_drained", 16'(eq.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/four_bank_mem_resp.md
# four_bank_mem_resp

Memory-side responder for the cache controller's memory request interface: it accepts word reads and writes on `addr`/`data_in`/`wr`/`rd` and returns `data_out`, `stall`, `busy` and `err`. Storage is split into four interleaved banks. Each accepted access occupies its bank for four cycles, and read data returns two cycles after acceptance. The block sits below the cache FSM and stands in for the main memory that the FSM's evict and fill sequences drive.

## Interface
- `MEM_WORDS_LOG2`, default 10: log2 of total 16-bit words across all banks; word index is `addr[MEM_WORDS_LOG2:1]`; higher address bits alias.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-low; `rst`=0 at a rising edge resets.
- `addr` input 16: byte address; bank = `addr[2:1]`.
- `data_in` input 16: write data, sampled on write acceptance.
- `wr` input 1: write request.
- `rd` input 1: read request.
- `data_out` output 16: read data, valid only in the return cycle, 0 otherwise.
- `stall` output 1: combinational; request present but its bank is busy, request not taken.
- `busy` output 4: registered per-bank occupancy, bit b = bank b.
- `err` output 1: registered one-cycle error pulse.

## Operation
- A request exists in a cycle when `rd|wr`=1. At most one request is accepted per cycle.
- Acceptance at the edge ending cycle T requires all of the following:
  - `rst`=1.
  - `busy[b]`=0 for b=`addr[2:1]`.
  - The request is not erroneous (see Configuration).
- **Accept write:** the word at index `addr[MEM_WORDS_LOG2:1]` is updated with `data_in` at that edge.
- **Accept read:** the array is read, then pipelined through two register stages.
- **Bank occupancy:** each bank has a 3-bit down-counter.
  - On acceptance the counter loads 4.
  - `busy[b]` = (counter != 0), so it is high for cycles T+1..T+4.
  - The counter decrements each cycle while nonzero.
- **Stall:** `stall` = (`rd|wr`) & `busy[addr[2:1]]`.
  - A stalled request has no side effects.
  - The requester holds `addr`/`data_in`/`wr`/`rd` until `stall` drops.
- **Erroneous request:** not accepted, leaves `busy` unchanged, and raises `err` in T+1 for one cycle. Its read pipeline slot is empty.
- **Stall wins over error:** a request to a busy bank stalls and does not flag `err` until it is presented to a free bank.
- **Read pipeline:** entries carry a valid bit.
  - `data_out` = stage-2 data when stage-2 is valid, else 16'h0000.
  - Reads to different banks in consecutive cycles return in consecutive cycles with no collision.
- **Reset:**
  - Clears all bank counters, pipeline valids and `err`.
  - In-flight reads are dropped and never return.
  - A write accepted in the cycle `rst`=0 is not performed.
  - Array contents are not cleared.

## Timing
- Output values in the cycle after reset: `data_out`=0, `busy`=4'b0000, `err`=0, `stall`=0 with no request present.
- **Read latency:** request accepted in cycle T, `data_out` valid in T+2 only.
- **Bank reuse:** the same bank can be accepted again at earliest in cycle T+5.
  - A request in T+1..T+4 to that bank sees `stall`=1.
  - Other banks are accepted every cycle.
- **Write-then-read:** a read of a word written in T returns the new data, since the earliest same-bank read is at T+5.
- **Error timing:** `err` is high in T+1 for an erroneous request in T, for one cycle even if the request is held. Each further held cycle produces another pulse.
- **`stall` timing:** combinational from `addr`, `rd`, `wr` and registered `busy`. No path from `stall` back into state.

## Configuration
- `MEM_REQ_CHECK_EN` defined: a non-stalled request is erroneous when `rd&wr`=1 or `addr[0]`=1. Erroneous requests are handled as in Operation.
- `MEM_REQ_CHECK_EN` undefined:
  - `err` is tied to 0.
  - `addr[0]` is ignored.
  - `rd&wr`=1 is treated as a write: the array is updated and the read pipeline stays empty.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `rd`=1 → `busy`=0, `data_out`=0, `err`=0. After release, the first read request is accepted with no stall.
- **Write/read bank 1:**
  - Cycle 0: write `addr`=16'h0002, `data_in`=16'hBEEF → `busy`=4'b0010 in cycles 1–4.
  - Cycle 2: read 16'h0002 → `stall`=1 in cycles 2–4 (request held), accepted in cycle 5.
  - `data_out`=16'hBEEF in cycle 7 only.
- **Back-to-back banks:**
  - Cycles 0–3: reads to 16'h0000, 16'h0002, 16'h0004, 16'h0006 (preloaded with 1, 2, 3, 4), each accepted with no stall.
  - `data_out` = 1, 2, 3, 4 in cycles 2–5.
  - `busy`=4'b1111 in cycle 4.
- **Error (macro on):**
  - Read `addr`=16'h0003 → `err`=1 next cycle, `busy` unchanged, `data_out` stays 0.
  - `rd`=`wr`=1 to 16'h0010 → `err` pulse, memory word unchanged.
- **Reset mid-read:** read 16'h0004 accepted in cycle 0; `rst`=0 in cycle 1 → `data_out`=0 in cycle 2, `busy`=0 in cycle 2.
- **Aliasing (MEM_WORDS_LOG2=10):** write 16'h0800 ← 16'h1234, then read 16'h0000 → 16'h1234.
